// File: rtl/majority_pkg.sv
// Shared definitions for the majority-voter BIST: controller state encoding,
// sweep size and the golden response of a 4-input majority voter.
package majority_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int VEC_COUNT = 16;
  localparam int VEC_W     = 4;
  localparam int ERR_W     = 5;

  // Golden voter response {R,T}: R when three or more inputs are high,
  // T on an exact 2-2 split (R is low in that case).
  function automatic logic [1:0] majority_expect(input logic [3:0] vec);
    logic [2:0] ones;
    ones = 3'(vec[0]) + 3'(vec[1]) + 3'(vec[2]) + 3'(vec[3]);
    majority_expect = {(ones >= 3'd3), (ones == 3'd2)};
  endfunction

endpackage

// File: rtl/majority_seq_ctrl.sv
// Sweep sequencer: walks the 16 input vectors through DRIVE, SETTLE and
// CHECK phases, holding each vector stable while the voter settles.
module majority_seq_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] vec,
  output logic       check,
  output logic       start_acc,
  output logic       busy,
  output logic       done
);
  import majority_pkg::*;

  // Last value of the settle counter before moving on; unused when the
  // settle phase is skipped entirely.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [3:0] VEC_LAST    = 4'(VEC_COUNT - 1);
  localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;

  // A start request only counts while no sweep is running.
  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State, vector and settle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= 4'd0;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          vec_d    = 4'd0;
          settle_d = 4'd0;
        end
      end
      ST_DRIVE: begin
        settle_d = 4'd0;
        state_d  = HAS_SETTLE ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        vec_d    = 4'd0;
        settle_d = 4'd0;
      end
    endcase
  end

  assign vec   = vec_q;
  assign check = (state_q == ST_CHECK);
  assign busy  = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done  = (state_q == ST_DONE);

endmodule

// File: rtl/majority_bist.sv
// Built-in self test for a 4-input majority voter: sweeps all input vectors,
// compares the returned {R,T} with the golden response and records the
// mismatch count and the first failing vector.
module majority_bist #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       R,
  input  logic       T,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);
  import majority_pkg::*;

  logic [3:0] vec;
  logic       check;
  logic       start_acc;
  logic [1:0] resp;
  logic [1:0] gold;
  logic       mismatch;

  logic [ERR_W-1:0] err_q;
  logic             fvalid_q;
  logic [VEC_W-1:0] fvec_q;

  // Counter that sticks at full scale instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    sat_inc = (cnt == {ERR_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  majority_seq_ctrl #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vec      (vec),
    .check    (check),
    .start_acc(start_acc),
    .busy     (busy),
    .done     (done)
  );

  assign {A, B, C, D} = vec;
  assign resp         = {R, T};
  assign gold         = majority_expect(vec);
  assign mismatch     = check && (resp != gold);

  // Result capture: cleared on every accepted start, updated on each CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else if (start_acc) begin
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else if (mismatch) begin
      err_q <= sat_inc(err_q);
      if (!fvalid_q) begin
        fvalid_q <= 1'b1;
        fvec_q   <= vec;
      end
    end
  end

  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
  assign pass       = done && (err_q == '0);

endmodule

// File: tb/tb_majority_bist.sv
// Bench for majority_bist: a bench-side voter with selectable faults, a
// sweep-level reference model, per-cycle output comparison and directed runs.
module tb_majority_bist;

  localparam int S     = 2;
  localparam int P     = S + 2;
  localparam int SWEEP = 16 * P;

  logic clk;
  logic rst;
  logic start, start0;
  logic A, B, C, D, R, T;
  logic busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] fail_vec;
  logic a0, b0, c0, d0, r0, t0;
  logic busy0, done0, pass0, fail_valid0;
  logic [4:0] err_count0;
  logic [3:0] fail_vec0;

  int          fault_mode;
  logic [15:0] flip_r, flip_t;
  int          checks, errors;
  bit          chk_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  majority_bist #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .C(C), .D(D), .R(R), .T(T),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  majority_bist #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .A(a0), .B(b0), .C(c0), .D(d0), .R(r0), .T(t0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .fail_valid(fail_valid0), .fail_vec(fail_vec0)
  );

  // Ideal voter response from the count of high inputs.
  function automatic logic [1:0] gold(input logic [3:0] v);
    int n;
    n = $countones(v);
    return {(n >= 3), (n == 2)};
  endfunction

  // Voter under test with injectable faults.
  function automatic logic [1:0] voter(input logic [3:0] v, input int mode,
                                       input logic [15:0] fr, input logic [15:0] ft);
    logic [1:0] g;
    g = gold(v);
    case (mode)
      1: g[1] = 1'b0;
      2: g[0] = ~g[0];
      3: g = g ^ {fr[v], ft[v]};
      default: ;
    endcase
    return g;
  endfunction

  assign {R, T}   = voter({A, B, C, D}, fault_mode, flip_r, flip_t);
  assign {r0, t0} = gold({a0, b0, c0, d0});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sweep-level reference: a running sweep is a cycle index k; vector k/P is
  // presented and judged on the last cycle of its slot.
  bit         m_run, m_done, m_fvalid;
  int         m_k, m_err;
  logic [3:0] m_fv, m_vec, m_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_done <= 0; m_k <= 0; m_err <= 0;
      m_fvalid <= 0; m_fv <= 4'd0; m_vec <= 4'd0;
    end else if (m_run) begin
      if (m_k % P == P - 1) begin
        m_v = 4'(m_k / P);
        if (voter(m_v, fault_mode, flip_r, flip_t) != gold(m_v)) begin
          m_err <= m_err + 1;
          if (!m_fvalid) begin
            m_fvalid <= 1;
            m_fv     <= m_v;
          end
        end
      end
      if (m_k + 1 == SWEEP) begin
        m_run  <= 0;
        m_done <= 1;
      end else begin
        m_k   <= m_k + 1;
        m_vec <= 4'((m_k + 1) / P);
      end
    end else if (start) begin
      m_run <= 1; m_done <= 0; m_k <= 0; m_err <= 0;
      m_fvalid <= 0; m_fv <= 4'd0; m_vec <= 4'd0;
    end
  end

  // Per-cycle comparison, sampled shortly after the active edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("vec", 32'({A, B, C, D}), 32'(m_vec));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_done && (m_err == 0)));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("fail_valid", 32'(fail_valid), 32'(m_fvalid));
      chk("fail_vec", 32'(fail_vec), 32'(m_fv));
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Counts busy cycles until the sweep ends; optionally pokes start mid-sweep.
  task automatic wait_sweep(input int poke_at, output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      start = (cyc == poke_at);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vec"}, 32'({A, B, C, D}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fvalid"}, 32'(fail_valid), 32'd0);
    chk({tag, "_fvec"}, 32'(fail_vec), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    checks = 0; errors = 0; chk_en = 0;
    rst = 1'b0; start = 1'b0; start0 = 1'b0;
    fault_mode = 0; flip_r = 16'h0; flip_t = 16'h0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    chk_en = 1;

    // Clean sweep with a correct voter.
    pulse_start();
    wait_sweep(-1, cyc);
    chk("clean_len", 32'(cyc), 32'd64);
    chk("clean_done", 32'(done), 32'd1);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_err", 32'(err_count), 32'd0);
    chk("clean_fvalid", 32'(fail_valid), 32'd0);
    chk("clean_hold_vec", 32'({A, B, C, D}), 32'hF);

    // R stuck at 0.
    fault_mode = 1;
    pulse_start();
    wait_sweep(-1, cyc);
    chk("rs0_err", 32'(err_count), 32'd5);
    chk("rs0_fvec", 32'(fail_vec), 32'h7);
    chk("rs0_fvalid", 32'(fail_valid), 32'd1);
    chk("rs0_pass", 32'(pass), 32'd0);

    // T inverted.
    fault_mode = 2;
    pulse_start();
    wait_sweep(-1, cyc);
    chk("tinv_err", 32'(err_count), 32'd16);
    chk("tinv_fvec", 32'(fail_vec), 32'h0);
    chk("tinv_fvalid", 32'(fail_valid), 32'd1);

    // Restart from a failing DONE with the voter fixed; start poked mid-sweep.
    fault_mode = 0;
    pulse_start();
    chk("restart_err_cleared", 32'(err_count), 32'd0);
    wait_sweep(20, cyc);
    chk("poke_len", 32'(cyc), 32'd64);
    chk("poke_pass", 32'(pass), 32'd1);

    // Abort at vector 0110.
    pulse_start();
    n = 0;
    while ({A, B, C, D} != 4'h6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_0110", 32'({A, B, C, D}), 32'h6);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk) rst = 1'b0;
    pulse_start();
    wait_sweep(-1, cyc);
    chk("after_abort_len", 32'(cyc), 32'd64);
    chk("after_abort_pass", 32'(pass), 32'd1);

    // Zero settle cycles.
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("s0_len", 32'(cyc), 32'd32);
    chk("s0_done", 32'(done0), 32'd1);
    chk("s0_pass", 32'(pass0), 32'd1);
    chk("s0_err", 32'(err_count0), 32'd0);

    // Randomized traffic: random starts, faults, rare resets, a held-start stretch.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = (i >= 1000 && i < 1400) ? 1'b1 : ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      if (!busy && $urandom_range(0, 3) == 0) begin
        fault_mode = int'($urandom_range(0, 3));
        flip_r     = 16'($urandom);
        flip_t     = 16'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/majority_bist.md
MAJORITY_BIST -- requirements
Module: majority_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of wait cycles between driving a vector and sampling the responder outputs (legal range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  run request, sampled only in IDLE or DONE.
REQ-005 A, B, C, D  output  1 each  stimulus vector bits to the majority voter under test; A is MSB, D is LSB.
REQ-006 R, T  input  1 each  voter result and tie outputs returned from the voter under test.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-009 pass  output  1  valid while done; 1 iff err_count==0.
REQ-010 err_count  output  5  number of mismatching vectors in the last sweep (0..16).
REQ-011 fail_valid  output  1  a mismatch has been captured this sweep.
REQ-012 fail_vec  output  4  first failing vector {A,B,C,D}; meaningful only when fail_valid=1.

Function
REQ-013 Golden model: expected R=1 iff popcount(vector)>=3; expected T=1 iff popcount==2; for popcount==2, R is expected 0.
REQ-014 FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 IDLE/DONE + start=1 -> DRIVE; vector counter=0, err_count=0, fail_valid=0, fail_vec=0, done=0 on that same edge.
REQ-016 DRIVE: A..D = counter for 1 cycle -> SETTLE if SETTLE_CYCLES>0, else CHECK.
REQ-017 SETTLE: hold A..D; stay exactly SETTLE_CYCLES cycles -> CHECK.
REQ-018 CHECK: compare sampled {R,T} with golden; on mismatch err_count+1 and, if fail_valid=0, fail_vec=counter and fail_valid=1.
REQ-019 CHECK with counter<15 -> counter+1, DRIVE; counter==15 -> DONE.
REQ-020 A..D hold the current vector from DRIVE through CHECK; they hold the last vector (1111) in DONE.
REQ-021 Each vector occupies SETTLE_CYCLES+2 cycles; a full sweep takes 16*(SETTLE_CYCLES+2) cycles from the first DRIVE cycle; done=1 on the cycle after the final CHECK.
REQ-022 busy=1 in DRIVE, SETTLE and CHECK; 0 in IDLE and DONE.
REQ-023 start while busy=1 is ignored; no restart, no effect on counters.
REQ-024 start held high in DONE restarts the sweep immediately; a continuously asserted start therefore loops sweeps back-to-back.
REQ-025 err_count never wraps; maximum value 16 fits 5 bits.
REQ-026 pass=0 whenever done=0.

Reset
REQ-027 rst=1 asynchronously forces IDLE, A..D=0000, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, settle counter=0.
REQ-028 Reset mid-sweep aborts it with no partial result retained; the first start after release begins at vector 0000.

Structure
REQ-029 Shared package majority_pkg holds the state enum, VEC_COUNT=16, and the golden function majority_expect(vec) returning {R,T}.
REQ-030 One sub-module: majority_seq_ctrl (FSM plus vector and settle counters); compare and capture logic stays in the top module.

Verification
REQ-031 Correct combinational voter, SETTLE_CYCLES=2, 1-cycle start -> busy for 64 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
REQ-032 Voter with R stuck-at-0 -> err_count=5 (vectors 0111, 1011, 1101, 1110, 1111), fail_vec=0111, pass=0.
REQ-033 Voter with T inverted -> err_count=16, fail_vec=0000, fail_valid=1.
REQ-034 rst pulsed mid-sweep at vector 0110 -> all outputs return to reset values immediately; a new start yields a full clean sweep with pass=1.
REQ-035 start pulsed during busy -> ignored, with sweep length unchanged; start in DONE after a failing run -> counters cleared, and with the voter fixed the new run gives pass=1.
REQ-036 SETTLE_CYCLES=0 -> sweep completes in 32 cycles with the correct voter, pass=1.
